// File: rtl/vert_pkg.sv
// Shared angle/cosine types and scheduler state encoding for the vertex pipeline.
// Pure declarations, no logic.
package vert_pkg;
    localparam int ANGLE_W   = 9;
    localparam int COS_W     = 12;
    localparam int ANGLE_MOD = 360;

    typedef logic [ANGLE_W-1:0]        angle_t;
    typedef logic signed [COS_W-1:0]   cos_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } vs_state_t;
endpackage

// File: rtl/angle_wrap_add.sv
// Combinational mod-360 angle adder; zero latency, no handshake.
// Both operands are below 360, so a single conditional subtract always lands in 0..359.
module angle_wrap_add
    import vert_pkg::*;
(
    input  logic [ANGLE_W-1:0] a,
    input  logic [ANGLE_W-1:0] b,
    output logic [ANGLE_W-1:0] sum
);
    logic [ANGLE_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        if (raw >= (ANGLE_W+1)'(ANGLE_MOD))
            sum = ANGLE_W'(raw - (ANGLE_W+1)'(ANGLE_MOD));
        else
            sum = ANGLE_W'(raw);
    end
endmodule

// File: rtl/vert_sched.sv
// Frame-synchronous vertex scheduler: per slot FETCH, ROM_LAT wait cycles, then EMIT held until tri_ready.
// Optional VERT_SCHED_PAUSE_EN adds a pause input that freezes the base angle in DONE.
module vert_sched
    import vert_pkg::*;
#(
    parameter int NUM_TRI       = 4,
    parameter int ANGLE_STEP    = 1,
    parameter int ANGLE_SPACING = 90,
    parameter int ROM_LAT       = 1
) (
    input  logic                    clk_pix,
    input  logic                    resetn,
`ifdef VERT_SCHED_PAUSE_EN
    input  logic                    pause,
`endif
    input  logic                    frame_start,
    output logic                    rom_req,
    output logic [ANGLE_W-1:0]      rom_angle,
    input  logic signed [COS_W-1:0] rom_cos,
    output logic                    tri_valid,
    input  logic                    tri_ready,
    output logic [3:0]              tri_idx,
    output logic signed [COS_W-1:0] tri_cos,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun
);
    vs_state_t  state;
    angle_t     base_angle;
    angle_t     cur_angle;
    angle_t     slot_next;
    angle_t     base_next;
    logic [3:0] idx;
    logic [2:0] wait_cnt;
    cos_t       cos_q;
    logic       hold_base;

`ifdef VERT_SCHED_PAUSE_EN
    assign hold_base = pause;
`else
    assign hold_base = 1'b0;
`endif

    angle_wrap_add u_slot_add (
        .a   (cur_angle),
        .b   (angle_t'(ANGLE_SPACING)),
        .sum (slot_next)
    );

    angle_wrap_add u_base_add (
        .a   (base_angle),
        .b   (angle_t'(ANGLE_STEP)),
        .sum (base_next)
    );

    always_ff @(posedge clk_pix) begin
        if (!resetn) begin
            state      <= S_IDLE;
            base_angle <= '0;
            cur_angle  <= '0;
            idx        <= '0;
            wait_cnt   <= '0;
            cos_q      <= '0;
            overrun    <= 1'b0;
        end else begin
            // A start pulse outside IDLE, including the DONE cycle, is dropped and flagged.
            if (frame_start && state != S_IDLE)
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        cur_angle <= base_angle;
                        idx       <= '0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    wait_cnt <= 3'(ROM_LAT);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        cos_q <= rom_cos;
                        state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (tri_ready) begin
                        if (idx == 4'(NUM_TRI - 1)) begin
                            state <= S_DONE;
                        end else begin
                            idx       <= idx + 4'd1;
                            cur_angle <= slot_next;
                            state     <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    if (!hold_base)
                        base_angle <= base_next;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rom_req    = (state == S_FETCH);
    assign rom_angle  = (state == S_FETCH) ? cur_angle : '0;
    assign tri_valid  = (state == S_EMIT);
    assign tri_idx    = idx;
    assign tri_cos    = cos_q;
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);
endmodule

// File: tb/tb_vert_sched.sv
// Directed bench for vert_sched with a one-cycle cosine ROM model that returns the angle as its value.
module tb_vert_sched;
    logic        clk_pix = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic        tri_ready = 1'b1;
    logic        pause = 1'b0;
    logic        rom_req;
    logic [8:0]  rom_angle;
    logic [11:0] rom_cos = 12'h800;
    logic        tri_valid;
    logic [3:0]  tri_idx;
    logic [11:0] tri_cos;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    int exp_base = 0;

    int n_req, n_hs, n_done, done_cyc, first_req_cyc, first_vld_cyc;
    logic [8:0]  req_ang [0:15];
    logic [3:0]  hs_idx  [0:15];
    logic [11:0] hs_cos  [0:15];

    vert_sched dut (
        .clk_pix     (clk_pix),
        .resetn      (resetn),
`ifdef VERT_SCHED_PAUSE_EN
        .pause       (pause),
`endif
        .frame_start (frame_start),
        .rom_req     (rom_req),
        .rom_angle   (rom_angle),
        .rom_cos     (rom_cos),
        .tri_valid   (tri_valid),
        .tri_ready   (tri_ready),
        .tri_idx     (tri_idx),
        .tri_cos     (tri_cos),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk_pix = ~clk_pix;

    // ROM model, latency 1: data is only meaningful in the cycle after the request.
    always @(posedge clk_pix)
        rom_cos <= rom_req ? {3'b000, rom_angle} : 12'h800;

    // Runs one frame with tri_ready high; optional extra frame_start pulse in cycle 'extra'.
    task automatic run_frame(input int extra);
        n_req = 0; n_hs = 0; n_done = 0;
        done_cyc = -1; first_req_cyc = -1; first_vld_cyc = -1;
        tri_ready = 1'b1;
        frame_start = 1'b1;
        @(negedge clk_pix);
        frame_start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (rom_req) begin
                if (first_req_cyc < 0) first_req_cyc = c;
                if (n_req < 16) req_ang[n_req] = rom_angle;
                n_req++;
            end
            if (tri_valid) begin
                if (first_vld_cyc < 0) first_vld_cyc = c;
                if (n_hs < 16) begin
                    hs_idx[n_hs] = tri_idx;
                    hs_cos[n_hs] = tri_cos;
                end
                n_hs++;
            end
            if (frame_done) begin
                if (done_cyc < 0) done_cyc = c;
                n_done++;
            end
            if (n_done > 0 && !busy) break;
            frame_start = (c == extra);
            @(negedge clk_pix);
            frame_start = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk_pix);
        checks++;
        if ({rom_req, rom_angle, tri_valid, tri_idx, tri_cos, busy, frame_done, overrun} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {rom_req, rom_angle, tri_valid, tri_idx, tri_cos, busy, frame_done, overrun});
        end
        resetn = 1'b1;
        @(negedge clk_pix);
        exp_base = 0;
    endtask

    task automatic test_basic_frame();
        logic [8:0] exp_ang;
        run_frame(-1);
        checks++;
        if (first_req_cyc !== 1) begin
            errors++; $display("FAIL first_req_cycle: got %0d required 1", first_req_cyc);
        end
        checks++;
        if (first_vld_cyc !== 3) begin
            errors++; $display("FAIL first_valid_cycle: got %0d required 3", first_vld_cyc);
        end
        checks++;
        if (n_req !== 4 || n_hs !== 4) begin
            errors++; $display("FAIL slot_counts: got req=%0d hs=%0d required 4/4", n_req, n_hs);
        end
        for (int i = 0; i < 4; i++) begin
            exp_ang = 9'(i * 90);
            checks++;
            if (req_ang[i] !== exp_ang || hs_idx[i] !== 4'(i) || hs_cos[i] !== {3'b000, exp_ang}) begin
                errors++;
                $display("FAIL slot%0d: got angle=%0d idx=%0d cos=%0d required %0d/%0d/%0d",
                         i, req_ang[i], hs_idx[i], hs_cos[i], exp_ang, i, exp_ang);
            end
        end
        checks++;
        if (done_cyc !== 13 || n_done !== 1) begin
            errors++; $display("FAIL frame_done_timing: got cycle=%0d count=%0d required 13/1", done_cyc, n_done);
        end
        exp_base = 1;
    endtask

    task automatic test_wrap();
        int bad = 0;
        for (int f = 2; f <= 359; f++) begin
            run_frame(-1);
            if (req_ang[0] !== 9'(exp_base) || n_done !== 1) bad++;
            exp_base = (exp_base + 1) % 360;
        end
        checks++;
        if (bad !== 0 || exp_base !== 359) begin
            errors++; $display("FAIL base_advance: got %0d bad frames required 0", bad);
        end
        run_frame(-1);
        checks++;
        if (req_ang[0] !== 9'd359 || req_ang[1] !== 9'd89 || req_ang[2] !== 9'd179) begin
            errors++;
            $display("FAIL slot_wrap: got %0d,%0d,%0d required 359,89,179", req_ang[0], req_ang[1], req_ang[2]);
        end
        exp_base = 0;
        run_frame(-1);
        checks++;
        if (req_ang[0] !== 9'd0) begin
            errors++; $display("FAIL base_wrap: got %0d required 0", req_ang[0]);
        end
        exp_base = 1;
    endtask

    task automatic test_backpressure();
        int found = 0;
        int stall_bad = 0;
        int req_seen = 0;
        int nd = 0;
        logic [8:0]  slot2_ang;
        logic [8:0]  slot3_ang;
        logic [8:0]  got3;
        slot2_ang = 9'((exp_base + 180) % 360);
        slot3_ang = 9'((exp_base + 270) % 360);
        got3 = 9'h1ff;
        tri_ready = 1'b1;
        frame_start = 1'b1;
        @(negedge clk_pix);
        frame_start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (tri_valid && tri_idx == 4'd2) begin
                found = 1;
                break;
            end
            @(negedge clk_pix);
        end
        tri_ready = 1'b0;
        checks++;
        if (found !== 1) begin
            errors++; $display("FAIL bp_reach_slot2: got %0d required 1", found);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_pix);
            if (!tri_valid || tri_idx !== 4'd2 || tri_cos !== {3'b000, slot2_ang}) stall_bad++;
            if (rom_req) req_seen++;
        end
        checks++;
        if (stall_bad !== 0) begin
            errors++; $display("FAIL bp_hold: got %0d unstable cycles required 0", stall_bad);
        end
        checks++;
        if (req_seen !== 0) begin
            errors++; $display("FAIL bp_no_rom: got %0d requests required 0", req_seen);
        end
        tri_ready = 1'b1;
        for (int c = 0; c <= 50; c++) begin
            if (rom_req) got3 = rom_angle;
            if (frame_done) nd++;
            if (nd > 0 && !busy) break;
            @(negedge clk_pix);
        end
        checks++;
        if (got3 !== slot3_ang || nd !== 1) begin
            errors++; $display("FAIL bp_resume: got angle=%0d done=%0d required %0d/1", got3, nd, slot3_ang);
        end
        exp_base = (exp_base + 1) % 360;
    endtask

    task automatic test_overrun();
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_clear: got %b required 0", overrun);
        end
        run_frame(5);
        checks++;
        if (overrun !== 1'b1 || n_done !== 1 || n_hs !== 4 || req_ang[0] !== 9'(exp_base)) begin
            errors++;
            $display("FAIL overrun_frame: got ovr=%b done=%0d hs=%0d a0=%0d required 1/1/4/%0d",
                     overrun, n_done, n_hs, req_ang[0], exp_base);
        end
        repeat (5) @(negedge clk_pix);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL overrun_sticky: got ovr=%b busy=%b required 1/0", overrun, busy);
        end
        exp_base = (exp_base + 1) % 360;
    endtask

    task automatic test_abort();
        int nd = 0;
        tri_ready = 1'b1;
        frame_start = 1'b1;
        @(negedge clk_pix);
        frame_start = 1'b0;
        repeat (4) @(negedge clk_pix);
        checks++;
        if ({busy, tri_valid, rom_req, tri_idx} !== 7'b100_0001) begin
            errors++; $display("FAIL abort_in_wait: got %b required 1000001", {busy, tri_valid, rom_req, tri_idx});
        end
        resetn = 1'b0;
        @(negedge clk_pix);
        checks++;
        if ({rom_req, rom_angle, tri_valid, tri_idx, tri_cos, busy, frame_done, overrun} !== 30'd0) begin
            errors++;
            $display("FAIL abort_outputs: got %b required all zero",
                     {rom_req, rom_angle, tri_valid, tri_idx, tri_cos, busy, frame_done, overrun});
        end
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_pix);
            if (frame_done) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++; $display("FAIL abort_no_done: got %0d pulses required 0", nd);
        end
        exp_base = 0;
    endtask

    task automatic test_done_overrun();
        run_frame(13);
        checks++;
        if (req_ang[0] !== 9'd0 || overrun !== 1'b1 || n_done !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle_start: got a0=%0d ovr=%b done=%0d busy=%b required 0/1/1/0",
                     req_ang[0], overrun, n_done, busy);
        end
        exp_base = 1;
    endtask

`ifdef VERT_SCHED_PAUSE_EN
    task automatic test_pause();
        int bad = 0;
        int dones = 0;
        pause = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame(-1);
            if (req_ang[0] !== 9'(exp_base)) bad++;
            dones += n_done;
        end
        pause = 1'b0;
        checks++;
        if (bad !== 0 || dones !== 3) begin
            errors++; $display("FAIL pause_hold: got bad=%0d dones=%0d required 0/3", bad, dones);
        end
        run_frame(-1);
        run_frame(-1);
        checks++;
        if (req_ang[0] !== 9'(exp_base + 1)) begin
            errors++; $display("FAIL pause_release: got %0d required %0d", req_ang[0], exp_base + 1);
        end
        exp_base = exp_base + 2;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_wrap();
        test_backpressure();
        test_overrun();
        test_abort();
        test_done_overrun();
`ifdef VERT_SCHED_PAUSE_EN
        test_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
